// File: rtl/ebi_pin_array.sv
// ebi_pin_array: EBI register-mapped array of square/PWM pin channels with phase restart and readable counters
// Optional pin sampling (MODE 5 and the SAMPLE register) is built only when PIN_SAMPLE_EN is defined.
module ebi_pin_array #(
    parameter int NUM_PINS  = 4,
    parameter int ADDR_W    = 19,
    parameter int BASE_ADDR = 32,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   ebi_addr,
    input  logic [15:0]         ebi_data_in,
    output logic [15:0]         ebi_data_out,
    input  logic                ebi_wr,
    input  logic                ebi_rd,
    input  logic                ebi_cs,
    input  logic [NUM_PINS-1:0] pin_in,
    output logic [NUM_PINS-1:0] pin_out,
    output logic [NUM_PINS-1:0] pin_oe
);
    logic [ADDR_W-1:0]   off;
    logic [ADDR_W-4:0]   chan;
    logic [2:0]          r;
    logic                hit;
    logic                wr_s1;
    logic                wr_s2;
    logic                wr_s3;
    logic                wr_vld;
    logic                wr_arm;
    logic                wr_en;
    logic [15:0]         rd_val [NUM_PINS];
    logic [15:0]         rd_mux;
    logic [NUM_PINS-1:0] drv;
    logic [NUM_PINS-1:0] oe;

    assign off  = ebi_addr - ADDR_W'(BASE_ADDR);
    assign chan = off[ADDR_W-1:3];
    assign r    = off[2:0];
    assign hit  = ebi_addr >= ADDR_W'(BASE_ADDR) && off < ADDR_W'(8 * NUM_PINS) && r != 3'd7;

    // wr_arm stays low until the synchronised strobe has been seen low, so a strobe held across reset is not an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_s1  <= 1'b0;
            wr_s2  <= 1'b0;
            wr_s3  <= 1'b0;
            wr_vld <= 1'b0;
            wr_arm <= 1'b0;
        end else begin
            wr_s1  <= ebi_wr;
            wr_s2  <= wr_s1;
            wr_s3  <= wr_s2;
            wr_vld <= 1'b1;
            wr_arm <= wr_arm | (wr_vld & ~wr_s1);
        end
    end

    assign wr_en = wr_arm && wr_s2 && !wr_s3 && ebi_cs && hit;

`ifdef PIN_SAMPLE_EN
    logic [NUM_PINS-1:0] pin_s1;
    logic [NUM_PINS-1:0] pin_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            pin_s1 <= '0;
            pin_s2 <= '0;
        end else begin
            pin_s1 <= pin_in;
            pin_s2 <= pin_s1;
        end
    end
`else
    logic unused_pins;
    assign unused_pins = ^pin_in;
`endif

    genvar c;
    generate
        for (c = 0; c < NUM_PINS; c++) begin : g_ch
            logic [2:0]       mode;
            logic [CNT_W-1:0] period;
            logic [CNT_W-1:0] duty;
            logic [CNT_W-1:0] phase;
            logic [CNT_W-1:0] count;
            logic [15:0]      sample;
            logic             run;
            logic             we;
            logic             restart;
            logic             wrap;
            logic             sq;
            logic             pwm;

            assign we      = wr_en && chan == (ADDR_W-3)'(c);
            assign restart = we && r == 3'd5 && ebi_data_in[1];
            assign wrap    = period < CNT_W'(2) || count >= period - CNT_W'(1);

            always_ff @(posedge clk) begin
                if (reset) begin
                    mode   <= '0;
                    period <= '0;
                    duty   <= '0;
                    phase  <= '0;
                    count  <= '0;
                    run    <= 1'b0;
                end else begin
                    if (we && r == 3'd0) mode <= ebi_data_in[2:0];
                    if (we && r == 3'd1) period <= ebi_data_in[CNT_W-1:0];
                    if (we && r == 3'd2) duty <= ebi_data_in[CNT_W-1:0];
                    if (we && r == 3'd3) phase <= ebi_data_in[CNT_W-1:0];
                    if (we && r == 3'd5) run <= ebi_data_in[0];
                    if (restart) count <= phase < period ? phase : '0;
                    else if (run) count <= wrap ? '0 : count + CNT_W'(1);
                end
            end

`ifdef PIN_SAMPLE_EN
            always_ff @(posedge clk) begin
                if (reset || restart) sample <= '0;
                else if (run && wrap && mode == 3'd5) sample <= {sample[14:0], pin_s2[c]};
            end
`else
            assign sample = '0;
`endif

            assign sq     = period < CNT_W'(2) || count < (period >> 1);
            assign pwm    = duty != '0 && (duty >= period || count < duty);
            assign drv[c] = mode == 3'd2 || (mode == 3'd3 && sq) || (mode == 3'd4 && pwm);
            assign oe[c]  = mode >= 3'd1 && mode <= 3'd4;

            assign rd_val[c] = r == 3'd0 ? 16'(mode) :
                               r == 3'd1 ? 16'(period) :
                               r == 3'd2 ? 16'(duty) :
                               r == 3'd3 ? 16'(phase) :
                               r == 3'd4 ? 16'(count) :
                               r == 3'd5 ? 16'(run) :
                               r == 3'd6 ? sample : 16'h0;
        end
    endgenerate

    always_comb begin
        rd_mux = 16'h0;
        for (int i = 0; i < NUM_PINS; i++)
            if (hit && chan == (ADDR_W-3)'(i)) rd_mux = rd_val[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pin_out      <= '0;
            pin_oe       <= '0;
            ebi_data_out <= '0;
        end else begin
            pin_out      <= drv;
            pin_oe       <= oe;
            ebi_data_out <= ebi_cs && ebi_rd ? rd_mux : 16'h0;
        end
    end
endmodule
